// File: rtl/csr_access_sequencer.sv
// Queues CSR commands, issues them one cycle each onto the Ibex CSR port, and returns ordered responses.
// Optional stop-on-illegal halting is enabled with `define CSR_SEQ_STOP_ON_ILLEGAL_EN.
module csr_access_sequencer #(
  parameter int unsigned CmdDepth = 4,
  parameter int unsigned RspDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [11:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        csr_access_o,
  output logic [1:0]  csr_op_o,
  output logic        csr_op_en_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        csr_illegal_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  output logic        halted_o,
  input  logic        halt_clr_i,
  output logic [15:0] issued_cnt_o,
  output logic [15:0] illegal_cnt_o
);

  localparam int unsigned CW = $clog2(CmdDepth);
  localparam int unsigned RW = $clog2(RspDepth);
  localparam logic [CW:0]   CmdFull = CmdDepth[CW:0];
  localparam logic [RW+1:0] RspLim  = RspDepth[RW+1:0];

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        illegal;
  } rsp_t;

  cmd_t cmd_mem_q [CmdDepth];
  rsp_t rsp_mem_q [RspDepth];

  state_e        state_q, state_d;
  logic [CW-1:0] cmd_wp_q, cmd_rp_q;
  logic [CW:0]   cmd_cnt_q;
  logic [RW-1:0] rsp_wp_q, rsp_rp_q;
  logic [RW:0]   rsp_cnt_q;
  logic [RW+1:0] rsp_need;
  logic          rdy_q;
  logic          cmd_push, cmd_pop;
  logic          rsp_push, rsp_pop;
  logic          halt_now;

  logic          acc_q, acc_d;
  logic [1:0]    op_q, op_d;
  logic [11:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   issued_q, illegal_q;

  assign cmd_ready_o = rdy_q & (cmd_cnt_q != CmdFull);
  assign cmd_push    = cmd_valid_i & cmd_ready_o;
  assign cmd_pop     = (state_d == ISSUE);
  assign rsp_push    = (state_q == ISSUE);
  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  // The cycle now in ISSUE will occupy a response slot at its ending edge.
  assign rsp_need    = {1'b0, rsp_cnt_q} + {{(RW+1){1'b0}}, rsp_push};

`ifdef CSR_SEQ_STOP_ON_ILLEGAL_EN
  logic halted_q;

  assign halt_now = halted_q | (rsp_push & csr_illegal_i);
  assign halted_o = halted_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halted_q <= 1'b0;
    end else if (rsp_push & csr_illegal_i) begin
      halted_q <= 1'b1;
    end else if (halt_clr_i) begin
      halted_q <= 1'b0;
    end
  end
`else
  logic unused_halt_clr;

  assign unused_halt_clr = halt_clr_i;
  assign halt_now        = 1'b0;
  assign halted_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if ((cmd_cnt_q != '0) && !halt_now && (rsp_need < RspLim)) begin
      state_d = ISSUE;
    end
  end

  always_comb begin
    acc_d   = 1'b0;
    op_d    = '0;
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == ISSUE) begin
      acc_d   = 1'b1;
      op_d    = cmd_mem_q[cmd_rp_q].op;
      addr_d  = cmd_mem_q[cmd_rp_q].addr;
      wdata_d = cmd_mem_q[cmd_rp_q].wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      acc_q   <= acc_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign csr_access_o = acc_q;
  assign csr_op_en_o  = acc_q;
  assign csr_op_o     = op_q;
  assign csr_addr_o   = addr_q;
  assign csr_wdata_o  = wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q     <= 1'b0;
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 1'b1;
      unique case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
        2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
        default: cmd_cnt_q <= cmd_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_mem_q[cmd_wp_q] <= cmd_t'{cmd_op_i, cmd_addr_i, cmd_wdata_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_wp_q  <= '0;
      rsp_rp_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (rsp_push) rsp_wp_q <= rsp_wp_q + 1'b1;
      if (rsp_pop)  rsp_rp_q <= rsp_rp_q + 1'b1;
      unique case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt_q <= rsp_cnt_q + 1'b1;
        2'b01:   rsp_cnt_q <= rsp_cnt_q - 1'b1;
        default: rsp_cnt_q <= rsp_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_push) begin
      rsp_mem_q[rsp_wp_q] <= rsp_t'{csr_rdata_i, csr_illegal_i};
    end
  end

  assign rsp_rdata_o   = rsp_valid_o ? rsp_mem_q[rsp_rp_q].rdata : '0;
  assign rsp_illegal_o = rsp_valid_o ? rsp_mem_q[rsp_rp_q].illegal : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (rsp_push) begin
      if (issued_q != 16'hFFFF) issued_q <= issued_q + 1'b1;
      if (csr_illegal_i && (illegal_q != 16'hFFFF)) begin
        illegal_q <= illegal_q + 1'b1;
      end
    end
  end

  assign issued_cnt_o  = issued_q;
  assign illegal_cnt_o = illegal_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer with a tiny CSR file stub and an in-order response model.
// Honours `define CSR_SEQ_STOP_ON_ILLEGAL_EN for the halt checks.
module tb_csr_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        csr_access_o, csr_op_en_o;
  logic [1:0]  csr_op_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        csr_illegal_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_illegal_o;
  logic        halted_o, halt_clr_i;
  logic [15:0] issued_cnt_o, illegal_cnt_o;

  localparam logic [1:0] OpRd = 2'd0, OpWr = 2'd1, OpSet = 2'd2, OpClr = 2'd3;
  localparam logic [31:0] IllData = 32'hBADC0FFE;

  always #5 clk = ~clk;

  csr_access_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .csr_access_o(csr_access_o), .csr_op_o(csr_op_o), .csr_op_en_o(csr_op_en_o),
    .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_rdata_i(csr_rdata_i), .csr_illegal_i(csr_illegal_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o),
    .halted_o(halted_o), .halt_clr_i(halt_clr_i),
    .issued_cnt_o(issued_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  int total = 0;
  int bad = 0;
  int access_seen = 0;
  int issued_exp = 0;
  int illegal_exp = 0;
  logic [32:0] exp_q [$];
  logic [32:0] got_q [$];
  logic [31:0] m_csr [logic [11:0]];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply(input logic [1:0] op, input logic [31:0] o,
                                        input logic [31:0] w);
    case (op)
      OpWr:    return w;
      OpSet:   return o | w;
      OpClr:   return o & ~w;
      default: return o;
    endcase
  endfunction

  function automatic bit legal(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h340) || (a == 12'h341);
  endfunction

  // CSR file stub: combinational read of the old value, write at the issuing edge
  logic [31:0] st300 = '0, st340 = '0, st341 = '0;
  always_comb begin
    csr_illegal_i = 1'b0;
    case (csr_addr_o)
      12'h300: csr_rdata_i = st300;
      12'h340: csr_rdata_i = st340;
      12'h341: csr_rdata_i = st341;
      default: begin
        csr_rdata_i   = IllData;
        csr_illegal_i = 1'b1;
      end
    endcase
  end

  always @(posedge clk) begin
    if (csr_access_o && csr_op_en_o) begin
      case (csr_addr_o)
        12'h300: st300 <= apply(csr_op_o, st300, csr_wdata_o);
        12'h340: st340 <= apply(csr_op_o, st340, csr_wdata_o);
        12'h341: st341 <= apply(csr_op_o, st341, csr_wdata_o);
        default: ;
      endcase
    end
  end

  // Per-cycle response compare against the in-order expectation queue
  always @(negedge clk) begin
    if (rst_ni) begin
      if (csr_access_o) access_seen++;
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'd0, rsp_valid_o}, 64'd0);
        end else begin
          chk("rsp_data", {31'd0, rsp_rdata_o, rsp_illegal_o}, {31'd0, exp_q[0]});
          if (rsp_ready_i) begin
            got_q.push_back({rsp_rdata_o, rsp_illegal_o});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
    int n;
    logic [31:0] o;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = a;
    cmd_wdata_i = w;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready_o) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
    end else begin
      issued_exp++;
      if (legal(a)) begin
        o = m_csr.exists(a) ? m_csr[a] : 32'd0;
        exp_q.push_back({o, 1'b0});
        m_csr[a] = apply(op, o, w);
      end else begin
        illegal_exp++;
        exp_q.push_back({IllData, 1'b1});
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, n;
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_op_i = '0;
    cmd_addr_i = '0;
    cmd_wdata_i = '0;
    rsp_ready_i = 1'b1;
    halt_clr_i = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_outs", {csr_access_o, csr_op_en_o, csr_op_o, csr_addr_o, csr_wdata_o,
                     rsp_valid_o, rsp_rdata_o, rsp_illegal_o, halted_o}, 64'd0);
    chk("rst_cnts", {issued_cnt_o, illegal_cnt_o}, 64'd0);
    cycles(2);
    chk("rst_cmd_ready_hold", 64'(cmd_ready_o), 64'd0);
    rst_ni = 1'b1;
    cycles(1);
    chk("cmd_ready_after_rst", 64'(cmd_ready_o), 64'd1);

    // Latency and mscratch write/read
    send(OpWr, 12'h340, 32'hDEADBEEF);
    chk("lat_n", 64'(csr_access_o), 64'd0);
    cycles(1);
    chk("lat_n1_access", {csr_access_o, csr_op_en_o, csr_op_o, csr_addr_o, csr_wdata_o},
        {1'b1, 1'b1, OpWr, 12'h340, 32'hDEADBEEF});
    chk("lat_n1_rsp", 64'(rsp_valid_o), 64'd0);
    cycles(1);
    chk("lat_n2_rsp", {rsp_valid_o, csr_access_o}, 64'b10);
    send(OpRd, 12'h340, 32'h0);
    drain();
    chk("wr_rsp_lit", 64'(got_q[0]), {31'd0, 32'h0, 1'b0});
    chk("rd_rsp_lit", 64'(got_q[1]), {31'd0, 32'hDEADBEEF, 1'b0});
    chk("issued_2", 64'(issued_cnt_o), 64'd2);

    // SET / CLEAR return the old value
    send(OpWr, 12'h340, 32'hF0);
    send(OpSet, 12'h340, 32'h0F);
    send(OpRd, 12'h340, 32'h0);
    send(OpClr, 12'h340, 32'h0F);
    send(OpRd, 12'h340, 32'h0);
    drain();
    chk("set_old_lit", 64'(got_q[3]), {31'd0, 32'hF0, 1'b0});
    chk("set_rd_lit", 64'(got_q[4]), {31'd0, 32'hFF, 1'b0});
    chk("clr_old_lit", 64'(got_q[5]), {31'd0, 32'hFF, 1'b0});
    chk("clr_rd_lit", 64'(got_q[6]), {31'd0, 32'hF0, 1'b0});

    // Unimplemented CSR
    send(OpRd, 12'hFFF, 32'h0);
    send(OpRd, 12'h340, 32'h0);
    a0 = access_seen;
    cycles(8);
`ifdef CSR_SEQ_STOP_ON_ILLEGAL_EN
    chk("halted_set", 64'(halted_o), 64'd1);
    chk("halt_blocks_issue", 64'(access_seen - a0), 64'd0);
    chk("halt_rsp_pending", 64'(exp_q.size()), 64'd1);
    halt_clr_i = 1'b1;
    cycles(1);
    halt_clr_i = 1'b0;
    chk("halted_clr", 64'(halted_o), 64'd0);
`else
    chk("halted_tied", 64'(halted_o), 64'd0);
    chk("no_halt_issue", 64'(exp_q.size()), 64'd0);
`endif
    drain();
    chk("illegal_lit", 64'(got_q[7]), {31'd0, IllData, 1'b1});
    chk("after_ill_lit", 64'(got_q[8]), {31'd0, 32'hF0, 1'b0});
    chk("illegal_cnt_1", 64'(illegal_cnt_o), 64'd1);

    // Response backpressure fills both FIFOs
    rsp_ready_i = 1'b0;
    a0 = access_seen;
    send(OpWr, 12'h341, 32'h11);
    send(OpWr, 12'h341, 32'h22);
    send(OpRd, 12'h341, 32'h0);
    send(OpSet, 12'h300, 32'h5);
    cycles(10);
    chk("bp_issues_4", 64'(access_seen - a0), 64'd4);
    chk("bp_access_idle", 64'(csr_access_o), 64'd0);
    send(OpRd, 12'h300, 32'h0);
    send(OpRd, 12'h341, 32'h0);
    send(OpWr, 12'h300, 32'h7);
    send(OpRd, 12'h300, 32'h0);
    chk("bp_cmd_full", 64'(cmd_ready_o), 64'd0);
    cycles(5);
    chk("bp_still_4", 64'(access_seen - a0), 64'd4);
    rsp_ready_i = 1'b1;
    drain();
    chk("bp_rd_lit", 64'(got_q[11]), {31'd0, 32'h22, 1'b0});
    chk("issued_model", 64'(issued_cnt_o), 64'(issued_exp));
    chk("illegal_model", 64'(illegal_cnt_o), 64'(illegal_exp));

    // Reset while issuing with commands queued
    rsp_ready_i = 1'b0;
    repeat (4) send(OpRd, 12'h341, 32'h0);
    cycles(10);
    repeat (4) send(OpRd, 12'h340, 32'h0);
    cycles(3);
    rsp_ready_i = 1'b1;
    cycles(1);
    rsp_ready_i = 1'b0;
    n = 0;
    while (!csr_access_o && n < 20) begin
      cycles(1);
      n++;
    end
    chk("rst_mid_issue", 64'(csr_access_o), 64'd1);
    rst_ni = 1'b0;
    exp_q.delete();
    issued_exp = 0;
    illegal_exp = 0;
    #1;
    chk("midrst_outs", {csr_access_o, csr_op_en_o, csr_op_o, csr_addr_o, csr_wdata_o,
                        rsp_valid_o, rsp_rdata_o, rsp_illegal_o, halted_o}, 64'd0);
    chk("midrst_ready", {cmd_ready_o, issued_cnt_o, illegal_cnt_o}, 64'd0);
    cycles(2);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    a0 = access_seen;
    cycles(12);
    chk("postrst_no_issue", 64'(access_seen - a0), 64'd0);
    chk("postrst_no_rsp", 64'(rsp_valid_o), 64'd0);
    chk("postrst_cnt", 64'(issued_cnt_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
